// File: rtl/wb_write_queue.sv
// wb_write_queue: register-file write arbiter for a primary (W-stage) write
// port and a secondary (multi-cycle unit) port. Secondary writes are held in
// a 4-entry FIFO and issued in cycles where the primary has nothing to write.
// A queued entry leaves the FIFO on the same edge that loads it into the grf
// registers, so busy1/busy2 only see writes that are still waiting.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   p_valid/p_a3/p_wd/p_pc  primary write request (never back-pressured)
//   s_valid/s_ready         secondary handshake; s_ready = (count < 4)
//   s_a3/s_wd/s_pc          secondary write payload
//   q_a1/q_a2, busy1/busy2  scoreboard query: register has a queued write
//   grf_en/a3/wd/pc         registered register-file write (values hold when idle)
//   count                   FIFO occupancy, 0..4
//
// Optional build macro: WBQ_DISPLAY_EN prints a trace line for every
// register-file write; the logic is identical with or without it.
module wb_write_queue (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_valid,
    input  logic [4:0]  p_a3,
    input  logic [31:0] p_wd,
    input  logic [31:0] p_pc,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [4:0]  s_a3,
    input  logic [31:0] s_wd,
    input  logic [31:0] s_pc,
    input  logic [4:0]  q_a1,
    input  logic [4:0]  q_a2,
    output logic        busy1,
    output logic        busy2,
    output logic        grf_en,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc,
    output logic [2:0]  count
);

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;
    localparam logic [2:0]  FULL  = 3'(DEPTH);

    // FIFO storage; only the valid bits need reset
    logic [AW-1:0]    ent_a3_q [DEPTH];
    logic [DW-1:0]    ent_wd_q [DEPTH];
    logic [DW-1:0]    ent_pc_q [DEPTH];
    logic [DEPTH-1:0] ent_vld_q;
    logic [1:0]       wr_ptr_q, rd_ptr_q;
    logic [2:0]       count_q, count_d;

    logic             grf_en_q;
    logic [AW-1:0]    grf_a3_q;
    logic [DW-1:0]    grf_wd_q;
    logic [DW-1:0]    grf_pc_q;

    logic p_issue, push, pop;

    // Arbitration: primary wins; zero destinations are dropped (but still handshaken)
    always_comb begin
        p_issue = p_valid && (p_a3 != '0);
        s_ready = (count_q < FULL);
        push    = s_valid && s_ready && (s_a3 != '0);
        pop     = !p_issue && (count_q != '0);
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 3'd1;
        end else if (pop && !push) begin
            count_d = count_q - 3'd1;
        end
    end

    // Scoreboard lookup over entries still waiting in the FIFO
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (ent_vld_q[i] && (q_a1 != '0) && (ent_a3_q[i] == q_a1)) busy1 = 1'b1;
            if (ent_vld_q[i] && (q_a2 != '0) && (ent_a3_q[i] == q_a2)) busy2 = 1'b1;
        end
    end

    // Control state and registered write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_vld_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            grf_en_q  <= 1'b0;
            grf_a3_q  <= '0;
            grf_wd_q  <= '0;
            grf_pc_q  <= '0;
        end else begin
            count_q  <= count_d;
            grf_en_q <= p_issue || pop;
            if (p_issue) begin
                grf_a3_q <= p_a3;
                grf_wd_q <= p_wd;
                grf_pc_q <= p_pc;
            end else if (pop) begin
                grf_a3_q <= ent_a3_q[rd_ptr_q];
                grf_wd_q <= ent_wd_q[rd_ptr_q];
                grf_pc_q <= ent_pc_q[rd_ptr_q];
            end
            // push and pop never target the same slot: push needs count<4, pop count>0
            if (pop) begin
                ent_vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q            <= rd_ptr_q + 2'd1;
            end
            if (push) begin
                ent_vld_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q            <= wr_ptr_q + 2'd1;
            end
        end
    end

    // FIFO payload write
    always_ff @(posedge clk) begin
        if (push) begin
            ent_a3_q[wr_ptr_q] <= s_a3;
            ent_wd_q[wr_ptr_q] <= s_wd;
            ent_pc_q[wr_ptr_q] <= s_pc;
        end
    end

    assign grf_en = grf_en_q;
    assign grf_a3 = grf_a3_q;
    assign grf_wd = grf_wd_q;
    assign grf_pc = grf_pc_q;
    assign count  = count_q;

`ifdef WBQ_DISPLAY_EN
    // Write trace
    always @(posedge clk) begin
        if (grf_en_q) begin
            $display("%d@%h: $%d <= %h", $time, grf_pc_q, grf_a3_q, grf_wd_q);
        end
    end
`else
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the write arbiter.
module tb_wb_write_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_valid;
    logic [4:0]  p_a3;
    logic [31:0] p_wd, p_pc;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_a3;
    logic [31:0] s_wd, s_pc;
    logic [4:0]  q_a1, q_a2;
    logic        busy1, busy2;
    logic        grf_en;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_pc;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    // reference model: pending secondary writes {a3, wd, pc} and last issued write
    logic [68:0] mq[$];
    logic        m_en;
    logic [4:0]  m_a3;
    logic [31:0] m_wd, m_pc;

    wb_write_queue dut (
        .clk(clk), .reset(reset),
        .p_valid(p_valid), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc),
        .s_valid(s_valid), .s_ready(s_ready), .s_a3(s_a3), .s_wd(s_wd), .s_pc(s_pc),
        .q_a1(q_a1), .q_a2(q_a2), .busy1(busy1), .busy2(busy2),
        .grf_en(grf_en), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic m_busy(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i][68:64] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_ready();
        return mq.size() < 4;
    endfunction

    task automatic m_clear();
        mq.delete();
        m_en = 1'b0; m_a3 = '0; m_wd = '0; m_pc = '0;
    endtask

    task automatic idle();
        p_valid = 1'b0; p_a3 = '0; p_wd = '0; p_pc = '0;
        s_valid = 1'b0; s_a3 = '0; s_wd = '0; s_pc = '0;
    endtask

    // advance model with current inputs, then clock the DUT and settle
    task automatic tick();
        logic acc;
        logic [68:0] h;
        acc = s_valid && m_ready();
        if (p_valid && p_a3 != 5'd0) begin
            m_en = 1'b1; m_a3 = p_a3; m_wd = p_wd; m_pc = p_pc;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            m_en = 1'b1; m_a3 = h[68:64]; m_wd = h[63:32]; m_pc = h[31:0];
        end else begin
            m_en = 1'b0;
        end
        if (acc && s_a3 != 5'd0) mq.push_back({s_a3, s_wd, s_pc});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); q_a1 = '0; q_a2 = '0;
        m_clear();
        #1;
        checks++;
        if ({grf_en, grf_a3, grf_wd, grf_pc, count} !== 73'd0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", {grf_en, grf_a3, grf_wd, grf_pc, count});
        end
        checks++;
        if ({s_ready, busy1, busy2} !== 3'b100) begin
            errors++; $display("FAIL reset_ready_busy got %b exp 100", {s_ready, busy1, busy2});
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_primary();
        idle();
        p_valid = 1'b1; p_a3 = 5'd5; p_wd = 32'h1234; p_pc = 32'h3000;
        tick();
        checks++;
        if ({grf_en, grf_a3, grf_wd, grf_pc} !== {1'b1, 5'd5, 32'h1234, 32'h3000}) begin
            errors++; $display("FAIL primary_issue got %b %0d %h %h exp 1 5 1234 3000", grf_en, grf_a3, grf_wd, grf_pc);
        end
        idle();
        tick();
        checks++;
        if ({grf_en, grf_a3, grf_wd, grf_pc} !== {1'b0, 5'd5, 32'h1234, 32'h3000}) begin
            errors++; $display("FAIL primary_hold got %b %0d %h %h exp 0 5 1234 3000", grf_en, grf_a3, grf_wd, grf_pc);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            idle();
            s_valid = 1'b1; s_a3 = 5'(i + 1); s_wd = $urandom; s_pc = $urandom;
            #1;
            checks++;
            if (s_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, s_ready);
            end
            tick();
            checks++;
            if ({grf_en, grf_a3, grf_wd, grf_pc, count} !== {m_en, m_a3, m_wd, m_pc, 3'(mq.size())} || count > 3'd4) begin
                errors++; $display("FAIL b2b_out[%0d] got %b %0d %h %h cnt %0d exp %b %0d %h %h cnt %0d",
                    i, grf_en, grf_a3, grf_wd, grf_pc, count, m_en, m_a3, m_wd, m_pc, mq.size());
            end
        end
        idle();
        tick();
        checks++;
        if ({grf_en, grf_a3, count} !== {1'b1, 5'd5, 3'd0}) begin
            errors++; $display("FAIL b2b_last got %b %0d cnt %0d exp 1 5 cnt 0", grf_en, grf_a3, count);
        end
    endtask

    task automatic test_primary_priority();
        for (int i = 0; i < 6; i++) begin
            idle();
            p_valid = 1'b1; p_a3 = 5'(i + 1); p_wd = $urandom; p_pc = $urandom;
            if (i < 5) begin
                s_valid = 1'b1; s_a3 = 5'(20 + i); s_wd = $urandom; s_pc = $urandom;
            end
            #1;
            checks++;
            if (s_ready !== m_ready() || (i == 4 && s_ready !== 1'b0)) begin
                errors++; $display("FAIL prio_ready[%0d] got %b exp %b", i, s_ready, m_ready());
            end
            tick();
            checks++;
            if ({grf_en, grf_a3, grf_wd, grf_pc} !== {1'b1, 5'(i + 1), m_wd, m_pc} || count !== 3'(mq.size())) begin
                errors++; $display("FAIL prio_primary[%0d] got %b %0d %h cnt %0d exp 1 %0d %h cnt %0d",
                    i, grf_en, grf_a3, grf_wd, count, i + 1, m_wd, mq.size());
            end
        end
        for (int k = 0; k < 4; k++) begin
            idle();
            tick();
            checks++;
            if ({grf_en, grf_a3, grf_wd, grf_pc} !== {1'b1, 5'(20 + k), m_wd, m_pc} || count !== 3'(3 - k)) begin
                errors++; $display("FAIL prio_drain[%0d] got %b %0d %h cnt %0d exp 1 %0d %h cnt %0d",
                    k, grf_en, grf_a3, grf_wd, count, 20 + k, m_wd, 3 - k);
            end
        end
    endtask

    task automatic test_busy();
        idle();
        p_valid = 1'b1; p_a3 = 5'd3; p_wd = $urandom; p_pc = $urandom;
        s_valid = 1'b1; s_a3 = 5'd9; s_wd = $urandom; s_pc = $urandom;
        q_a1 = 5'd9; q_a2 = 5'd0;
        #1;
        checks++;
        if ({busy1, busy2} !== 2'b00) begin
            errors++; $display("FAIL busy_empty got %b exp 00", {busy1, busy2});
        end
        tick();
        s_valid = 1'b0;
        #1;
        checks++;
        if ({busy1, busy2} !== {m_busy(q_a1), m_busy(q_a2)} || {busy1, busy2} !== 2'b10) begin
            errors++; $display("FAIL busy_queued got %b exp 10", {busy1, busy2});
        end
        tick();
        p_valid = 1'b0;
        #1;
        checks++;
        if (busy1 !== 1'b1) begin
            errors++; $display("FAIL busy_waiting got %b exp 1", busy1);
        end
        tick();
        checks++;
        if ({grf_en, grf_a3, busy1, busy2} !== {1'b1, 5'd9, 2'b00}) begin
            errors++; $display("FAIL busy_issued got %b %0d %b%b exp 1 9 00", grf_en, grf_a3, busy1, busy2);
        end
        q_a1 = '0;
    endtask

    task automatic test_zero_dest();
        idle();
        tick();
        s_valid = 1'b1; s_a3 = 5'd0; s_wd = $urandom; s_pc = $urandom;
        p_valid = 1'b1; p_a3 = 5'd0; p_wd = $urandom; p_pc = $urandom;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL zero_ready got %b exp 1", s_ready);
        end
        tick();
        checks++;
        if ({grf_en, count} !== {1'b0, 3'd0} || count !== 3'(mq.size())) begin
            errors++; $display("FAIL zero_drop got en %b cnt %0d exp en 0 cnt 0", grf_en, count);
        end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 3; i++) begin
            idle();
            p_valid = 1'b1; p_a3 = 5'd1; p_wd = $urandom; p_pc = $urandom;
            s_valid = 1'b1; s_a3 = 5'(10 + i); s_wd = $urandom; s_pc = $urandom;
            tick();
        end
        idle();
        q_a1 = 5'd10; q_a2 = 5'd12;
        #1;
        checks++;
        if ({count, busy1, busy2} !== {3'd3, 2'b11}) begin
            errors++; $display("FAIL midop_pre got cnt %0d busy %b%b exp cnt 3 busy 11", count, busy1, busy2);
        end
        reset = 1'b1;
        #1;
        m_clear();
        checks++;
        if ({count, grf_en, grf_a3, busy1, busy2, s_ready} !== {3'd0, 1'b0, 5'd0, 2'b00, 1'b1}) begin
            errors++; $display("FAIL midop_reset got cnt %0d en %b a3 %0d busy %b%b rdy %b exp 0 0 0 00 1",
                count, grf_en, grf_a3, busy1, busy2, s_ready);
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({grf_en, count} !== {1'b0, 3'd0}) begin
                errors++; $display("FAIL midop_after[%0d] got en %b cnt %0d exp 0 0", k, grf_en, count);
            end
        end
        q_a1 = '0; q_a2 = '0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            p_valid = ($urandom_range(2) == 0);
            p_a3 = 5'($urandom_range(7)); p_wd = $urandom; p_pc = $urandom;
            s_valid = $urandom_range(1) == 1;
            s_a3 = 5'($urandom_range(7)); s_wd = $urandom; s_pc = $urandom;
            q_a1 = 5'($urandom_range(7)); q_a2 = 5'($urandom_range(7));
            #1;
            checks++;
            if ({s_ready, busy1, busy2} !== {m_ready(), m_busy(q_a1), m_busy(q_a2)}) begin
                errors++; $display("FAIL rand_comb[%0d] got %b%b%b exp %b%b%b", n, s_ready, busy1, busy2,
                    m_ready(), m_busy(q_a1), m_busy(q_a2));
            end
            tick();
            checks++;
            if ({grf_en, grf_a3, grf_wd, grf_pc, count} !== {m_en, m_a3, m_wd, m_pc, 3'(mq.size())}) begin
                errors++; $display("FAIL rand_out[%0d] got %b %0d %h %h cnt %0d exp %b %0d %h %h cnt %0d",
                    n, grf_en, grf_a3, grf_wd, grf_pc, count, m_en, m_a3, m_wd, m_pc, mq.size());
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_primary();
        test_back_to_back();
        test_primary_priority();
        test_busy();
        test_zero_dest();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-high reset, reset.
REQ-002 Port list SHALL be:
  clk     in   1   rising-edge clock
  reset   in   1   asynchronous, active-high
  p_valid in   1   primary (W-stage) write request, no backpressure
  p_a3    in   5   primary destination register
  p_wd    in   32  primary write data
  p_pc    in   32  primary instruction PC
  s_valid in   1   secondary (multi-cycle unit) write request
  s_ready out  1   secondary request accepted when s_valid & s_ready at clk edge
  s_a3    in   5   secondary destination register
  s_wd    in   32  secondary write data
  s_pc    in   32  secondary instruction PC
  q_a1    in   5   scoreboard query register 1
  q_a2    in   5   scoreboard query register 2
  busy1   out  1   q_a1 has a queued write pending
  busy2   out  1   q_a2 has a queued write pending
  grf_en  out  1   register-file write enable
  grf_a3  out  5   register-file write address
  grf_wd  out  32  register-file write data
  grf_pc  out  32  PC of issued write
  count   out  3   FIFO occupancy, 0..4

Function
REQ-003 The block SHALL issue at most one register-file write per cycle; grf_en, grf_a3, grf_wd, and grf_pc SHALL be registered, with a latency of 1 cycle from the selecting edge.
REQ-004 Secondary requests SHALL be buffered in a 4-entry FIFO holding {a3, wd, pc}; s_ready = (count < 4), depending only on registered occupancy, with no same-cycle pass-through when full.
REQ-005 Priority per cycle SHALL be: a primary request with p_valid=1 and p_a3!=0 is issued; otherwise, if the FIFO is non-empty, the FIFO head is issued and popped; otherwise grf_en=0 on the next cycle.
REQ-006 The primary SHALL always win arbitration; the FIFO head SHALL wait, unmodified, while primary requests continue.
REQ-007 Requests with a3=0, from either source, SHALL be dropped. Such a secondary request SHALL still be handshaken (accepted) but SHALL NOT be enqueued, and it SHALL NOT produce a write.
REQ-008 A push and a pop in the same cycle SHALL leave count unchanged, and a pop SHALL occur before the full check of the following cycle.
REQ-009 FIFO pointers SHALL be 2-bit and wrap from 3 to 0; order SHALL be strictly first-in first-out.
REQ-010 busy1 SHALL be 1 iff q_a1!=0 and any valid FIFO entry has a3==q_a1; busy2 SHALL follow the same rule for q_a2. Both SHALL be combinational from the FIFO state, excluding the entry being issued in the current registered output.
REQ-011 The block SHALL perform no WAW squashing between sources; the hazard unit stalls on busy1/busy2.
REQ-012 When grf_en=0, grf_a3, grf_wd, and grf_pc SHALL hold their previous values.

Reset
REQ-013 On reset assertion, asynchronously: grf_en=0, grf_a3=0, grf_wd=0, grf_pc=0, count=0, pointers=0, and all entries invalid; s_ready=1 and busy1=busy2=0 thereafter.
REQ-014 Reset asserted mid-operation SHALL discard all queued writes without issuing them; the first issue after reset deassertion SHALL occur no earlier than 1 cycle after the first accepted request.

Configuration
REQ-015 With macro WBQ_DISPLAY_EN defined, each cycle with grf_en=1 SHALL print "%d@%h: $%d <= %h" using time, grf_pc, grf_a3, and grf_wd; without WBQ_DISPLAY_EN, no display statements SHALL be compiled in and the logic SHALL be otherwise identical.

Verification
REQ-016 Scenario: primary only, p_a3=5, p_wd=0x1234, p_pc=0x3000 -> next cycle grf_en=1, grf_a3=5, grf_wd=0x1234, grf_pc=0x3000.
REQ-017 Scenario: 5 back-to-back secondary requests with primary idle and writes drained as issued -> none refused, issued in order, count never exceeds 4.
REQ-018 Scenario: primary held valid for 6 cycles while 4 secondary entries are queued -> s_ready=0 on the 5th secondary attempt, primary writes issue for 6 cycles, then the FIFO drains in order over 4 cycles.
REQ-019 Scenario: queue entry with a3=9, q_a1=9, q_a2=0 -> busy1=1, busy2=0; after that entry issues, busy1=0.
REQ-020 Scenario: s_a3=0 request, and p_valid with p_a3=0 -> s_ready handshake completes, count stays 0, grf_en stays 0.
REQ-021 Scenario: reset asserted with 3 entries queued -> immediately count=0, grf_en=0, busy1=busy2=0, and no queued write appears afterwards.
